scpad_dram_req_arbiter: RTL and testbench
=========================================

// Module: scpad_dram_req_arbiter
// PURPOSE
//  Shares the single scratchpad-to-DRAM request queue between NUM_REQ backend requesters
//  (scpad load/store engines). Accepts one burst descriptor at a time from a requester.
//  Expands it into per-beat queue writes with sub_id and an incrementing address.
//  Holds the grant until the queue reports burst_complete, then re-arbitrates round-robin.
// PARAMETERS
//  NUM_REQ     2   number of requesters (2..4)
//  ADDR_W      32  DRAM byte-address width
//  ID_W        4   DRAM transaction id width
//  BEAT_BYTES  32  address increment per beat (power of 2)
// PORTS
//  CLK              in   1            clock
//  RST              in   1            synchronous reset, active-high
//  req_valid        in   NUM_REQ      requester i has a descriptor
//  req_write        in   NUM_REQ      1 = scpad store (DRAM write)
//  req_addr         in   NUM_REQ*ADDR_W  burst base address, slice i
//  req_id           in   NUM_REQ*ID_W    transaction id, slice i
//  req_num_request  in   NUM_REQ*3    beats-1 (0..7 -> 1..8 beats), slice i
//  req_ready        out  NUM_REQ      one-hot accept pulse; descriptor latched this edge
//  req_done         out  NUM_REQ      one-hot pulse when granted burst completes
//  q_valid          out  1            beat presented to request queue
//  q_sched_write    out  1            latched req_write
//  q_dram_addr      out  ADDR_W       base + sub_id*BEAT_BYTES, mod 2^ADDR_W
//  q_id             out  ID_W         latched id
//  q_sub_id         out  3            beat index 0..num_request
//  q_num_request    out  3            latched beats-1
//  dram_queue_full  in   1            queue cannot take a beat this cycle
//  burst_complete   in   1            queue finished current burst
//  busy             out  1            state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr 0, beat counter 0. RST mid-burst abandons burst; no req_done.
//  FSM IDLE -> ISSUE -> WAIT_CMPL -> IDLE.
//  IDLE: grant = first asserted req_valid at or after rr_ptr (wrapping); req_ready[grant] comb.
//   Descriptor latched on the edge; next state ISSUE; rr_ptr <= grant+1 mod NUM_REQ.
//   No req_valid: stay IDLE.
//  ISSUE: q_valid=1. A beat is accepted on an edge with q_valid && !dram_queue_full.
//   On accept: sub_id++, addr += BEAT_BYTES.
//   Full: hold all q_* stable, no advance. Accept of sub_id==num_request -> WAIT_CMPL.
//   One beat/cycle max; num_request=0 issues exactly one beat.
//  WAIT_CMPL: q_valid=0; on burst_complete pulse req_done[grant] for 1 cycle, -> IDLE.
//  burst_complete in IDLE/ISSUE: ignored. Return to IDLE costs one bubble cycle before next grant.
//  Requester must hold req_valid/fields stable until req_ready; fields ignored afterwards.
//  Address adds wrap silently at 2^ADDR_W.
// CONFIGURATION
//  SCPAD_ARB_FIXED_PRIO_EN defined: grant = lowest-index asserted req_valid; rr_ptr unused (held 0).
//  Undefined (default): round-robin as above.
// TESTING
//  1. Single req0, addr=0x1000, nr=3, full=0 -> ready0 t0; beats t1..t4 sub_id 0..3, addr 0x1000/20/40/60.
//  1 (cont.) burst_complete t6 -> done0 t6, busy=0 t7.
//  2. req0,req1 always valid, nr=0 -> grants alternate 0,1,0,1 (fixed-prio build: 0,0,0,0).
//  3. Full high during sub_id=1 for 3 cycles -> q_* frozen at sub_id 1, beat count still nr+1, no dup.
//  4. addr=0xFFFFFFE0, nr=1 -> beats addr 0xFFFFFFE0, 0x00000000.
//  5. RST asserted in ISSUE at sub_id 2 -> next cycle all outputs 0, IDLE; later req granted from rr_ptr 0.
//  6. burst_complete pulsed in IDLE and mid-ISSUE -> no req_done, no state change.

Source files
------------

// File: rtl/scpad_dram_req_arbiter.sv
// ---------------------------------------------------------------------------
// scpad_dram_req_arbiter
//
// Shares the single scratchpad-to-DRAM request queue between NUM_REQ backend
// requesters. One burst descriptor is accepted at a time. It is expanded into
// one queue write per beat, each carrying a beat index (sub_id) and a
// BEAT_BYTES-incrementing address. The grant is held until the queue reports
// burst_complete, after which arbitration resumes.
//
// Arbitration:
//   default                  : round-robin starting at rr_ptr
//   SCPAD_ARB_FIXED_PRIO_EN  : lowest-index requester wins, rr_ptr held at 0
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req_valid[i]        requester i presents a descriptor
//   req_write[i]        1 = DRAM write (scpad store)
//   req_addr[i]         burst base byte address (ADDR_W slice i)
//   req_id[i]           transaction id (ID_W slice i)
//   req_num_request[i]  beats-1 (3-bit slice i)
//   req_ready           one-hot accept pulse, descriptor latched on this edge
//   req_done            one-hot pulse when the granted burst completes
//   q_valid             beat presented to the request queue
//   q_sched_write       latched write flag
//   q_dram_addr         base + sub_id*BEAT_BYTES (wraps at 2^ADDR_W)
//   q_id                latched id
//   q_sub_id            beat index 0..num_request
//   q_num_request       latched beats-1
//   dram_queue_full     queue cannot take a beat this cycle
//   burst_complete      queue finished the current burst
//   busy                arbiter not idle
// ---------------------------------------------------------------------------
module scpad_dram_req_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned ID_W       = 4,
   parameter int unsigned BEAT_BYTES = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*ID_W-1:0]   req_id,
   input  logic [NUM_REQ*3-1:0]      req_num_request,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        req_done,
   output logic                      q_valid,
   output logic                      q_sched_write,
   output logic [ADDR_W-1:0]         q_dram_addr,
   output logic [ID_W-1:0]           q_id,
   output logic [2:0]                q_sub_id,
   output logic [2:0]                q_num_request,
   input  logic                      dram_queue_full,
   input  logic                      burst_complete,
   output logic                      busy
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_CMPL = 2'd2
   } state_e;

   // Registered state
   state_e              state_q,    state_d;
   logic [PTR_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
   logic                write_q,    write_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [ID_W-1:0]     id_q,       id_d;
   logic [2:0]          sub_id_q,   sub_id_d;
   logic [2:0]          nr_q,       nr_d;

   // Arbitration result for the current cycle
   logic                sel_found;
   logic [NUM_REQ-1:0]  sel_oh;
   logic [PTR_W-1:0]    sel_next_ptr;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [ID_W-1:0]     sel_id;
   logic [2:0]          sel_nr;

   // Two passes give the wrapping search: the first only considers indices
   // at or above rr_ptr, the second (reached only if the first found nothing)
   // considers all indices from 0. With rr_ptr held at 0 this degenerates to
   // fixed lowest-index priority.
   always_comb begin
      sel_found    = 1'b0;
      sel_oh       = '0;
      sel_next_ptr = '0;
      sel_write    = 1'b0;
      sel_addr     = '0;
      sel_id       = '0;
      sel_nr       = '0;
      for (int unsigned pass = 0; pass < 2; pass++) begin
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!sel_found && req_valid[j] &&
                ((pass == 1) || (j >= 32'(rr_ptr_q)))) begin
               sel_found    = 1'b1;
               sel_oh[j]    = 1'b1;
               sel_next_ptr = PTR_W'((j + 1) % NUM_REQ);
               sel_write    = req_write[j];
               sel_addr     = req_addr[j*ADDR_W +: ADDR_W];
               sel_id       = req_id[j*ID_W +: ID_W];
               sel_nr       = req_num_request[j*3 +: 3];
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_oh_d = grant_oh_q;
      write_d    = write_q;
      addr_d     = addr_q;
      id_d       = id_q;
      sub_id_d   = sub_id_q;
      nr_d       = nr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               grant_oh_d = sel_oh;
               write_d    = sel_write;
               addr_d     = sel_addr;
               id_d       = sel_id;
               nr_d       = sel_nr;
               sub_id_d   = '0;
`ifdef SCPAD_ARB_FIXED_PRIO_EN
               rr_ptr_d   = '0;
`else
               rr_ptr_d   = sel_next_ptr;
`endif
               state_d    = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // Beat accepted on this edge. The last beat leaves sub_id/addr
            // on the final beat so the q_* fields stay meaningful afterwards.
            if (!dram_queue_full) begin
               if (sub_id_q == nr_q) begin
                  state_d = ST_WAIT_CMPL;
               end else begin
                  sub_id_d = sub_id_q + 3'd1;
                  addr_d   = addr_q + ADDR_W'(BEAT_BYTES);
               end
            end
         end

         ST_WAIT_CMPL: begin
            if (burst_complete) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_oh_q <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         id_q       <= '0;
         sub_id_q   <= '0;
         nr_q       <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_oh_q <= grant_oh_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         sub_id_q   <= sub_id_d;
         nr_q       <= nr_d;
      end
   end

   // Handshake pulses are gated by RST so that nothing is accepted or
   // reported complete while a burst is being abandoned.
   always_comb begin
      req_ready = '0;
      req_done  = '0;
      if (!RST && (state_q == ST_IDLE) && sel_found) begin
         req_ready = sel_oh;
      end
      if (!RST && (state_q == ST_WAIT_CMPL) && burst_complete) begin
         req_done = grant_oh_q;
      end
   end

   assign q_valid       = (state_q == ST_ISSUE);
   assign busy          = (state_q != ST_IDLE);
   assign q_sched_write = write_q;
   assign q_dram_addr   = addr_q;
   assign q_id          = id_q;
   assign q_sub_id      = sub_id_q;
   assign q_num_request = nr_q;

endmodule

// File: tb/tb_scpad_dram_req_arbiter.sv
module tb_scpad_dram_req_arbiter;

   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned ID_W       = 4;
   localparam int unsigned BEAT_BYTES = 32;

   logic                      CLK = 1'b0;
   logic                      RST;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*ID_W-1:0]   req_id;
   logic [NUM_REQ*3-1:0]      req_num_request;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_done;
   logic                      q_valid;
   logic                      q_sched_write;
   logic [ADDR_W-1:0]         q_dram_addr;
   logic [ID_W-1:0]           q_id;
   logic [2:0]                q_sub_id;
   logic [2:0]                q_num_request;
   logic                      dram_queue_full;
   logic                      burst_complete;
   logic                      busy;

   always #5 CLK = ~CLK;

   scpad_dram_req_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ADDR_W    (ADDR_W),
      .ID_W      (ID_W),
      .BEAT_BYTES(BEAT_BYTES)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_id         (req_id),
      .req_num_request(req_num_request),
      .req_ready      (req_ready),
      .req_done       (req_done),
      .q_valid        (q_valid),
      .q_sched_write  (q_sched_write),
      .q_dram_addr    (q_dram_addr),
      .q_id           (q_id),
      .q_sub_id       (q_sub_id),
      .q_num_request  (q_num_request),
      .dram_queue_full(dram_queue_full),
      .burst_complete (burst_complete),
      .busy           (busy)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  id;
      logic [2:0]  sub;
      logic [2:0]  nr;
   } beat_t;

   beat_t       exp_beats[$];
   int unsigned exp_grants[$];
   int unsigned last_grant = 0;
   int          checks = 0;
   int          errors = 0;
   logic        auto_cmpl = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: a grant pushes the expected beat stream built from
   // the descriptor the bench drove; every accepted beat pops and compares.
   beat_t prev_beat;
   logic  prev_stall = 1'b0;

   always @(negedge CLK) begin
      beat_t       cur;
      int unsigned g;
      if (RST) begin
         prev_stall = 1'b0;
      end else begin
         if (req_ready != '0) begin
            g = 0;
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
            check_eq("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            if (exp_grants.size() > 0) check_eq("grant", 64'(g), 64'(exp_grants.pop_front()));
            else check_eq("grant_unexp", 64'(req_ready), 64'd0);
            last_grant = g;
            for (int k = 0; k <= int'(req_num_request[g*3 +: 3]); k++) begin
               beat_t b;
               b.wr   = req_write[g];
               b.addr = req_addr[g*32 +: 32] + 32'(k) * 32'(BEAT_BYTES);
               b.id   = req_id[g*4 +: 4];
               b.sub  = 3'(k);
               b.nr   = req_num_request[g*3 +: 3];
               exp_beats.push_back(b);
            end
         end
         if (q_valid) begin
            cur = {q_sched_write, q_dram_addr, q_id, q_sub_id, q_num_request};
            if (prev_stall) check_eq("stall_hold", 64'(cur), 64'(prev_beat));
            if (!dram_queue_full) begin
               if (exp_beats.size() > 0) check_eq("beat", 64'(cur), 64'(exp_beats.pop_front()));
               else check_eq("beat_unexp", 64'(q_valid), 64'd0);
            end
            prev_stall = dram_queue_full;
            prev_beat  = cur;
         end else begin
            prev_stall = 1'b0;
         end
         if (req_done != '0) check_eq("done", 64'(req_done), 64'(1) << last_grant);
      end
   end

   // One cycle step; auto-completion asserts burst_complete while waiting.
   task automatic tick();
      @(posedge CLK);
      #1;
      burst_complete = auto_cmpl && busy && !q_valid && !RST;
   endtask

   task automatic set_req(input int unsigned i, input logic v, input logic w,
                          input logic [31:0] a, input logic [3:0] id, input logic [2:0] nr);
      req_valid[i]             = v;
      req_write[i]             = w;
      req_addr[i*32 +: 32]     = a;
      req_id[i*4 +: 4]         = id;
      req_num_request[i*3 +: 3] = nr;
   endtask

   task automatic issue(input int unsigned i, input logic w, input logic [31:0] a,
                        input logic [3:0] id, input logic [2:0] nr);
      int unsigned n = 0;
      exp_grants.push_back(i);
      set_req(i, 1'b1, w, a, id, nr);
      while (n < 50) begin
         @(negedge CLK);
         if (req_ready[i]) break;
         tick();
         n++;
      end
      check_eq("issue_ready", 64'(req_ready[i]), 64'd1);
      tick();
      req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((busy || exp_beats.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      check_eq("drain_busy", 64'(busy), 64'd0);
      check_eq("drain_beats", 64'(exp_beats.size()), 64'd0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      req_valid = '0;
      dram_queue_full = 1'b0;
      burst_complete = 1'b0;
      exp_beats.delete();
      exp_grants.delete();
      tick();
      tick();
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      RST = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_id = '0; req_num_request = '0;
      dram_queue_full = 1'b0;
      burst_complete = 1'b0;
      do_reset();

      // Reset state
      @(negedge CLK);
      check_eq("reset_outs", 64'({req_ready, req_done, q_valid, q_sched_write, q_id, q_sub_id,
                                  q_num_request, busy}), 64'd0);
      check_eq("reset_addr", 64'(q_dram_addr), 64'd0);

      // 1: single burst, exact timing
      auto_cmpl = 1'b0;
      tick();
      exp_grants.push_back(0);
      set_req(0, 1'b0, 1'b0, 32'h1000, 4'h5, 3'd3);
      req_valid[0] = 1'b1;
      @(negedge CLK);
      check_eq("t1_ready", 64'(req_ready), 64'b01);
      tick();
      req_valid[0] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         check_eq("t1_qvalid", 64'(q_valid), 64'd1);
         tick();
      end
      @(negedge CLK);
      check_eq("t1_wait", 64'({q_valid, busy}), 64'b01);
      tick();
      burst_complete = 1'b1;
      @(negedge CLK);
      check_eq("t1_done", 64'(req_done), 64'b01);
      tick();
      @(negedge CLK);
      check_eq("t1_idle", 64'(busy), 64'd0);
      auto_cmpl = 1'b1;
      drain();

      // 2: both requesters always valid, one-beat bursts
      do_reset();
`ifdef SCPAD_ARB_FIXED_PRIO_EN
      exp_grants.push_back(0); exp_grants.push_back(0);
      exp_grants.push_back(0); exp_grants.push_back(0);
`else
      exp_grants.push_back(0); exp_grants.push_back(1);
      exp_grants.push_back(0); exp_grants.push_back(1);
`endif
      set_req(0, 1'b1, 1'b0, 32'h2000, 4'h1, 3'd0);
      set_req(1, 1'b1, 1'b1, 32'h3000, 4'h2, 3'd0);
      n = 0;
      while (n < 100) begin
         tick();
         if (exp_grants.size() == 0) break;
         n++;
      end
      req_valid = '0;
      check_eq("t2_grants_left", 64'(exp_grants.size()), 64'd0);
      drain();

      // 3: backpressure during sub_id 1
      issue(1, 1'b1, 32'h4000, 4'h9, 3'd3);
      n = 0;
      while (!(q_valid && q_sub_id == 3'd1) && n < 20) begin
         tick();
         n++;
      end
      check_eq("t3_sub1", 64'(q_sub_id), 64'd1);
      dram_queue_full = 1'b1;
      repeat (3) tick();
      dram_queue_full = 1'b0;
      drain();

      // 4: address wrap
      issue(0, 1'b0, 32'hFFFF_FFE0, 4'h3, 3'd1);
      drain();

      // 5: reset mid-burst, then arbitration restarts at requester 0
      auto_cmpl = 1'b0;
      issue(0, 1'b1, 32'h8000, 4'h7, 3'd5);
      n = 0;
      while (!(q_valid && q_sub_id == 3'd2) && n < 20) begin
         tick();
         n++;
      end
      check_eq("t5_sub2", 64'(q_sub_id), 64'd2);
      RST = 1'b1;
      exp_beats.delete();
      tick();
      @(negedge CLK);
      check_eq("t5_rst_outs", 64'({req_ready, req_done, q_valid, q_sched_write, q_id, q_sub_id,
                                   q_num_request, busy}), 64'd0);
      check_eq("t5_rst_addr", 64'(q_dram_addr), 64'd0);
      tick();
      RST = 1'b0;
      auto_cmpl = 1'b1;
      exp_grants.push_back(0);
      set_req(0, 1'b1, 1'b0, 32'h9000, 4'hA, 3'd0);
      set_req(1, 1'b1, 1'b0, 32'hA000, 4'hB, 3'd0);
      @(negedge CLK);
      check_eq("t5_regrant", 64'(req_ready), 64'b01);
      tick();
      req_valid = '0;
      drain();

      // 6: stray burst_complete in IDLE and mid-ISSUE
      auto_cmpl = 1'b0;
      tick();
      burst_complete = 1'b1;
      @(negedge CLK);
      check_eq("t6_idle_bc", 64'({req_done, busy}), 64'd0);
      tick();
      issue(0, 1'b0, 32'h5000, 4'h4, 3'd2);
      burst_complete = 1'b1;
      @(negedge CLK);
      check_eq("t6_issue_bc", 64'({req_done, q_valid}), 64'b001);
      n = 0;
      tick();
      while (!(busy && !q_valid) && n < 20) begin
         tick();
         n++;
      end
      burst_complete = 1'b1;
      @(negedge CLK);
      check_eq("t6_done", 64'(req_done), 64'b01);
      tick();
      @(negedge CLK);
      check_eq("t6_idle", 64'(busy), 64'd0);
      auto_cmpl = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
